kp_midi_note_ctrl: RTL and testbench

//  MIDI-side driver for the Karplus-Strong voice. Parses the byte stream from the UART receiver,

---
 rtl/kp_midi_pkg.sv | 16 +
 rtl/kp_pitch_rom.sv | 36 +++
 rtl/kp_midi_note_ctrl.sv | 148 ++++++++++++++
 tb/tb_kp_midi_note_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_midi_pkg.sv
// Shared types and constants for the MIDI note controller feeding the Karplus-Strong voice.
package kp_midi_pkg;
  localparam logic [3:0]  NOTE_OFF  = 4'h8;
  localparam logic [3:0]  NOTE_ON   = 4'h9;
  localparam logic [3:0]  PROG      = 4'hC;
  localparam logic [3:0]  CHPRESS   = 4'hD;
  localparam logic [10:0] DELAY_MAX = 11'd2047;

  typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} pstate_t;
  typedef enum logic [1:0] {T_IDLE, T_LOW, T_GUARD} tstate_t;

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] vel;
  } note_ev_t;
endpackage

// File: rtl/kp_pitch_rom.sv
// Note number -> delay-line length, round(96000/f_note) clamped to DELAY_MAX; 1-cycle read.
module kp_pitch_rom
  import kp_midi_pkg::*;
(
  input  logic        a_clk,
  input  logic        en,
  input  logic [6:0]  addr,
  output logic [10:0] dout
);
  // Notes below 31 all exceed the delay-line length, so only 31..127 are tabulated.
  localparam logic [6:0] FIRST = 7'd31;
  localparam logic [10:0] TBL [0:96] = '{
    11'd1959, 11'd1849, 11'd1745, 11'd1647, 11'd1555, 11'd1468, 11'd1385, 11'd1308,
    11'd1234, 11'd1165, 11'd1100, 11'd1038, 11'd980,  11'd925,  11'd873,
    11'd824,  11'd778,  11'd734,  11'd693,  11'd654,  11'd617,  11'd582,  11'd550,
    11'd519,  11'd490,  11'd462,  11'd436,
    11'd412,  11'd389,  11'd367,  11'd346,  11'd327,  11'd309,  11'd291,  11'd275,
    11'd259,  11'd245,  11'd231,  11'd218,
    11'd206,  11'd194,  11'd183,  11'd173,  11'd163,  11'd154,  11'd146,  11'd137,
    11'd130,  11'd122,  11'd116,  11'd109,
    11'd103,  11'd97,   11'd92,   11'd87,   11'd82,   11'd77,   11'd73,   11'd69,
    11'd65,   11'd61,   11'd58,   11'd55,
    11'd51,   11'd49,   11'd46,   11'd43,   11'd41,   11'd39,   11'd36,   11'd34,
    11'd32,   11'd31,   11'd29,   11'd27,
    11'd26,   11'd24,   11'd23,   11'd22,   11'd20,   11'd19,   11'd18,   11'd17,
    11'd16,   11'd15,   11'd14,   11'd14,
    11'd13,   11'd12,   11'd11,   11'd11,   11'd10,   11'd10,   11'd9,    11'd9,
    11'd8,    11'd8
  };

  logic [6:0] idx;
  assign idx = addr - FIRST;

  always_ff @(posedge a_clk)
    if (en) dout <= (addr < FIRST) ? DELAY_MAX : TBL[idx];
endmodule

// File: rtl/kp_midi_note_ctrl.sv
// MIDI byte parser plus trigger sequencer driving the KP voice trig/velocity/delay_length/gate.
module kp_midi_note_ctrl
  import kp_midi_pkg::*;
#(
  parameter logic [3:0]  MIDI_CH   = 4'd0,
  parameter int          TRIG_HOLD = 8,
  parameter logic [10:0] DEF_DELAY = 11'd218
)(
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        trig,
  output logic [6:0]  velocity,
  output logic [10:0] delay_length,
  output logic        gate,
  output logic [6:0]  note_num
);
  localparam logic [7:0] HOLD_M1 = 8'(TRIG_HOLD - 1);

  pstate_t    pst, pst_nxt;
  logic [7:0] rs, rs_nxt;
  logic       rs_vld, rs_vld_nxt;
  logic [6:0] d1, d1_nxt;
  logic       on_stb, off_stb;

  tstate_t    tst, tst_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       fire;
  logic       pend;
  note_ev_t   pev;
  logic [10:0] pdelay;

  // Parser: realtime bytes (F8..FF) fall through every branch untouched.
  always_comb begin
    pst_nxt    = pst;
    rs_nxt     = rs;
    rs_vld_nxt = rs_vld;
    d1_nxt     = d1;
    on_stb     = 1'b0;
    off_stb    = 1'b0;
    if (rx_valid) begin
      if (rx_data[7:3] == 5'b11110) begin
        rs_vld_nxt = 1'b0;
        pst_nxt    = P_IDLE;
      end else if (rx_data[7] && rx_data[7:4] != 4'hF) begin
        rs_nxt     = rx_data;
        rs_vld_nxt = 1'b1;
        pst_nxt    = P_D1;
      end else if (!rx_data[7]) begin
        case (pst)
          P_D2: begin
            pst_nxt = P_D1;
            if (rs[3:0] == MIDI_CH) begin
              on_stb  = (rs[7:4] == NOTE_ON) && (rx_data[6:0] != 7'd0);
              off_stb = (rs[7:4] == NOTE_OFF) ||
                        ((rs[7:4] == NOTE_ON) && (rx_data[6:0] == 7'd0));
            end
          end
          default: if (pst == P_D1 || rs_vld) begin
            if (rs[7:4] == PROG || rs[7:4] == CHPRESS) begin
              pst_nxt = P_D1;
            end else begin
              d1_nxt  = rx_data[6:0];
              pst_nxt = P_D2;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge a_clk or negedge reset_n)
    if (!reset_n) begin
      pst    <= P_IDLE;
      rs     <= '0;
      rs_vld <= 1'b0;
      d1     <= '0;
    end else begin
      pst    <= pst_nxt;
      rs     <= rs_nxt;
      rs_vld <= rs_vld_nxt;
      d1     <= d1_nxt;
    end

  // The ROM output register doubles as the pending delay; it only moves on a note-on.
  kp_pitch_rom u_rom (
    .a_clk (a_clk),
    .en    (on_stb),
    .addr  (d1),
    .dout  (pdelay)
  );

  // Trigger sequencer: a queued note fires straight out of the last guard cycle.
  always_comb begin
    tst_nxt = tst;
    cnt_nxt = cnt;
    fire    = 1'b0;
    case (tst)
      T_IDLE:  fire = pend;
      T_LOW:   if (cnt == HOLD_M1) begin
                 tst_nxt = T_GUARD;
                 cnt_nxt = '0;
               end else cnt_nxt = cnt + 8'd1;
      T_GUARD: if (cnt == HOLD_M1) begin
                 fire    = pend;
                 tst_nxt = T_IDLE;
               end else cnt_nxt = cnt + 8'd1;
      default: tst_nxt = T_IDLE;
    endcase
    if (fire) begin
      tst_nxt = T_LOW;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge a_clk or negedge reset_n)
    if (!reset_n) begin
      tst          <= T_IDLE;
      cnt          <= '0;
      trig         <= 1'b1;
      pend         <= 1'b0;
      pev          <= '0;
      velocity     <= '0;
      delay_length <= DEF_DELAY;
      note_num     <= '0;
      gate         <= 1'b0;
    end else begin
      tst  <= tst_nxt;
      cnt  <= cnt_nxt;
      trig <= (tst_nxt != T_LOW);
      if (on_stb) begin
        pend     <= 1'b1;
        pev.note <= d1;
        pev.vel  <= rx_data[6:0];
      end else if (fire) begin
        pend <= 1'b0;
      end
      if (fire) begin
        velocity     <= pev.vel;
        delay_length <= pdelay;
        note_num     <= pev.note;
        gate         <= !(off_stb && d1 == pev.note);
      end else if (off_stb && d1 == note_num && gate) begin
        gate <= 1'b0;
      end
    end
endmodule

// File: tb/tb_kp_midi_note_ctrl.sv
// Bench for kp_midi_note_ctrl: directed scenarios plus random MIDI traffic against a behavioural model.
module tb_kp_midi_note_ctrl;
  logic        a_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        trig, gate;
  logic [6:0]  velocity, note_num;
  logic [10:0] delay_length;

  int vectors = 0;
  int miscompares = 0;
  int falls = 0;
  int shown = 0;

  kp_midi_note_ctrl #(.MIDI_CH(4'd0), .TRIG_HOLD(8), .DEF_DELAY(11'd218)) dut (
    .a_clk        (a_clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .trig         (trig),
    .velocity     (velocity),
    .delay_length (delay_length),
    .gate         (gate),
    .note_num     (note_num)
  );

  always #5 a_clk = ~a_clk;

  function automatic int pitch(input int k);
    real d;
    d = 96000.0 / (440.0 * (2.0 ** ((k - 69) / 12.0)));
    if (d > 2047.0) return 2047;
    return $rtoi(d + 0.5);
  endfunction

  // Behavioural model: MIDI running-status semantics and a pulse/guard countdown.
  int rs = -1, nd = 0, b1 = 0;
  bit m_pend = 0;
  int p_note = 0, p_vel = 0, p_del = 0;
  int low_rem = 0, guard_rem = 0;
  int m_vel = 0, m_del = 218, m_note = 0;
  bit m_gate = 0;

  always @(posedge a_clk or negedge reset_n) begin
    bit on, off, fire;
    int dn, dv, b, hi;
    if (!reset_n) begin
      rs = -1; nd = 0; b1 = 0; m_pend = 0; low_rem = 0; guard_rem = 0;
      m_vel = 0; m_del = 218; m_note = 0; m_gate = 0;
    end else begin
      on = 0; off = 0; dn = 0; dv = 0;
      if (rx_valid) begin
        b = int'(rx_data);
        if (b >= 'hF0 && b < 'hF8) begin
          rs = -1; nd = 0;
        end else if (b >= 'h80 && b < 'hF0) begin
          rs = b; nd = 0;
        end else if (b < 'h80 && rs >= 0) begin
          hi = rs >> 4;
          if (hi == 'hC || hi == 'hD) nd = 0;
          else if (nd == 0) begin b1 = b; nd = 1; end
          else begin
            nd = 0;
            if ((rs & 15) == 0) begin
              if (hi == 'h9 && b > 0) begin on = 1; dn = b1; dv = b; end
              else if (hi == 'h9 || hi == 'h8) begin off = 1; dn = b1; end
            end
          end
        end
      end
      fire = m_pend && low_rem == 0 && guard_rem <= 1;
      if (low_rem > 0) begin
        low_rem--;
        if (low_rem == 0) guard_rem = 8;
      end else if (guard_rem > 0) guard_rem--;
      if (fire) begin
        low_rem = 8; guard_rem = 0;
        m_vel = p_vel; m_del = p_del; m_note = p_note;
        m_gate = !(off && dn == p_note);
      end else if (off && dn == m_note && m_gate) m_gate = 0;
      if (on) begin
        m_pend = 1; p_note = dn; p_vel = dv; p_del = pitch(dn);
      end else if (fire) m_pend = 0;
    end
  end

  logic trig_q = 1'b1;
  always @(negedge a_clk) begin
    vectors++;
    if (trig !== (low_rem == 0) || velocity !== 7'(m_vel) || delay_length !== 11'(m_del) ||
        gate !== m_gate || note_num !== 7'(m_note)) begin
      miscompares++;
      if (shown < 20)
        $display("FAIL cycle t=%0t: trig %b/%b vel %0d/%0d delay %0d/%0d gate %b/%b note %0d/%0d (got/required)",
                 $time, trig, (low_rem == 0), velocity, m_vel, delay_length, m_del, gate, m_gate, note_num, m_note);
      shown++;
    end
    if (trig_q && !trig) falls++;
    trig_q = trig;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge a_clk); #1; rx_data = b; rx_valid = 1'b1;
    @(posedge a_clk); #1; rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge a_clk);
  endtask

  task automatic wait_trig(input logic lvl, input string name);
    int n;
    n = 0;
    @(negedge a_clk);
    while (trig !== lvl && n < 200) begin @(negedge a_clk); n++; end
    chk(name, int'(trig === lvl), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, lows, hi, r;
    logic [7:0] b;

    chk("pitch A4", pitch(69), 218);
    chk("pitch C4", pitch(60), 367);
    chk("pitch 127", pitch(127), 8);
    chk("pitch 30 clamp", pitch(30), 2047);

    repeat (3) @(negedge a_clk);
    chk("reset trig", int'(trig), 1);
    chk("reset delay", int'(delay_length), 218);
    chk("reset gate", int'(gate), 0);
    reset_n = 1'b1;

    // 1: basic note-on, trig falls at N+2 for 8 cycles
    send(8'h90); send(8'h45); send(8'h64);
    @(negedge a_clk); chk("t1 trig N+1", int'(trig), 1);
    @(negedge a_clk); chk("t1 trig N+2", int'(trig), 0);
    chk("t1 delay", int'(delay_length), 218);
    chk("t1 vel", int'(velocity), 100);
    chk("t1 gate", int'(gate), 1);
    chk("t1 note", int'(note_num), 69);
    lows = 1;
    repeat (12) begin @(negedge a_clk); if (!trig) lows++; end
    chk("t1 low width", lows, 8);
    idle(20);

    // 2: running status, note-off via velocity 0
    send(8'h90); send(8'h3C); send(8'h40);
    wait_trig(1'b0, "t2 fall");
    chk("t2 delay", int'(delay_length), 367);
    chk("t2 vel", int'(velocity), 64);
    idle(20);
    f0 = falls;
    send(8'h3C); send(8'h00);
    @(negedge a_clk); chk("t2 gate off", int'(gate), 0);
    idle(30); chk("t2 no retrig", falls - f0, 0);

    // 3: channel filter and realtime byte
    f0 = falls;
    send(8'h91); send(8'h45); send(8'h64);
    idle(30); chk("t3 other ch", falls - f0, 0);
    chk("t3 note kept", int'(note_num), 60);
    send(8'h90); send(8'hF8); send(8'h45); send(8'h64);
    wait_trig(1'b0, "t3 rt fall");
    chk("t3 rt note", int'(note_num), 69);
    idle(30);

    // 4: second note-on during T_LOW, guard gap exactly 8
    send(8'h90); send(8'h7F); send(8'h10);
    @(negedge a_clk); @(negedge a_clk);
    chk("t4 p1 low", int'(trig), 0);
    chk("t4 p1 delay", int'(delay_length), 8);
    send(8'h90); send(8'h1E); send(8'h7F);
    wait_trig(1'b1, "t4 rise");
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin hi++; @(negedge a_clk); end
    chk("t4 guard gap", hi, 8);
    chk("t4 p2 delay", int'(delay_length), 2047);
    chk("t4 p2 vel", int'(velocity), 127);
    idle(30);

    // 5: three note-ons inside one pulse -> two pulses, last wins
    f0 = falls;
    send(8'h90); send(8'h40); send(8'h50);
    send(8'h41); send(8'h51);
    send(8'h42); send(8'h52);
    idle(60);
    chk("t5 pulses", falls - f0, 2);
    chk("t5 note", int'(note_num), 'h42);
    chk("t5 vel", int'(velocity), 'h52);

    // 6: async reset mid-pulse
    send(8'h90); send(8'h45); send(8'h64);
    @(negedge a_clk); @(negedge a_clk);
    #2 reset_n = 1'b0;
    #1 chk("t6 trig async", int'(trig), 1);
    chk("t6 vel", int'(velocity), 0);
    chk("t6 delay", int'(delay_length), 218);
    chk("t6 gate", int'(gate), 0);
    chk("t6 note", int'(note_num), 0);
    @(negedge a_clk); reset_n = 1'b1;
    f0 = falls;
    idle(30); chk("t6 no replay", falls - f0, 0);
    send(8'hF0); send(8'h45); send(8'h64);
    idle(30); chk("t6 sysex clears rs", falls - f0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      b = 8'h90;
      else if (r < 14) b = 8'h80;
      else if (r < 17) b = 8'h91;
      else if (r < 19) b = 8'hC0;
      else if (r < 21) b = 8'hF8;
      else if (r < 22) b = 8'hF0;
      else if (r < 23) b = 8'hB0;
      else if (r < 27) b = 8'h00;
      else if (r < 65) b = 8'($urandom_range(58, 62));
      else             b = 8'($urandom_range(0, 127));
      send(b);
      idle(int'($urandom_range(0, 10)));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
